// File: rtl/ram_handshake.sv
// rtl/ram_handshake.sv - single-port RAM with Req/Ack handshake and programmable latency
// Optional post-reset sweep of the whole array to CLEAR_VALUE when RAM_CLEAR_EN is defined.
module ram_handshake #(
    parameter int                 ADDR_W      = 16,
    parameter int                 DATA_W      = 10,
    parameter int                 LATENCY     = 1,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              CS,
    input  logic              Req,
    input  logic              WE_n,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] In,
    output wire  [DATA_W-1:0] Out,
    output logic              Ack,
    output logic              Busy,
    output logic              Ready
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [2:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_n_q;
    logic [DATA_W-1:0]   data_q;
    logic                ack_q;
    logic                busy_q;
    logic                ready_q;
`ifdef RAM_CLEAR_EN
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);
    logic [ADDR_W:0]     ptr_q;
`endif

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Writes land only on the final ACCESS edge (or a sweep edge), so a reset mid-access never writes.
    always_comb begin
        mem_we    = Rst_n && ((state_q == S_ACCESS && cnt_q == 3'd0 && !we_n_q)
                              || state_q == S_CLEAR);
        mem_waddr = addr_q;
        mem_wdata = (state_q == S_CLEAR) ? CLEAR_VALUE : wdata_q;
`ifdef RAM_CLEAR_EN
        if (state_q == S_CLEAR) begin
            mem_waddr = ptr_q[ADDR_W-1:0];
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
`ifdef RAM_CLEAR_EN
            state_q <= S_CLEAR;
            ready_q <= 1'b0;
            ptr_q   <= '0;
`else
            state_q <= S_IDLE;
            ready_q <= 1'b1;
`endif
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_n_q  <= 1'b1;
            data_q  <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_CLEAR: begin
`ifdef RAM_CLEAR_EN
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                S_IDLE: begin
                    if (CS && Req && ready_q) begin
                        addr_q  <= Address;
                        wdata_q <= In;
                        we_n_q  <= WE_n;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_INIT;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        if (we_n_q) begin
                            data_q <= mem[addr_q];
                        end
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Out   = CS ? data_q : {DATA_W{1'bz}};
    assign Ack   = ack_q;
    assign Busy  = busy_q;
    assign Ready = ready_q;

endmodule

// File: tb/tb_ram_handshake.sv
// tb/tb_ram_handshake.sv - three latency variants (1, 2, 8) driven in parallel against a transaction-level model
module tb_ram_handshake;

    localparam int              AW    = 4;
    localparam int              DW    = 10;
    localparam int              DEPTH = 16;
    localparam logic [DW-1:0]   CV    = 10'h3FF;
    localparam logic [DW-1:0]   PULL  = {DW{1'b1}};
`ifdef RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           cs    = 1'b0;
    logic           req   = 1'b0;
    logic           we_n  = 1'b1;
    logic [AW-1:0]  addr  = '0;
    logic [DW-1:0]  din   = '0;

    wire  [DW-1:0]  out1, out2, out8;
    logic           ack1, ack2, ack8;
    logic           busy1, busy2, busy8;
    logic           rdy1, rdy2, rdy8;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Released bus reads as all ones, so a tri-stated Out is observable.
    pullup pu1 (out1);
    pullup pu2 (out2);
    pullup pu8 (out8);

    ram_handshake #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1), .CLEAR_VALUE(CV)) u_l1 (
        .Clk(clk), .Rst_n(rst_n), .CS(cs), .Req(req), .WE_n(we_n), .Address(addr), .In(din),
        .Out(out1), .Ack(ack1), .Busy(busy1), .Ready(rdy1));
    ram_handshake #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2), .CLEAR_VALUE(CV)) u_l2 (
        .Clk(clk), .Rst_n(rst_n), .CS(cs), .Req(req), .WE_n(we_n), .Address(addr), .In(din),
        .Out(out2), .Ack(ack2), .Busy(busy2), .Ready(rdy2));
    ram_handshake #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(8), .CLEAR_VALUE(CV)) u_l8 (
        .Clk(clk), .Rst_n(rst_n), .CS(cs), .Req(req), .WE_n(we_n), .Address(addr), .In(din),
        .Out(out8), .Ack(ack8), .Busy(busy8), .Ready(rdy8));

    function automatic int lat(int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 8;
    endfunction
    function automatic logic [DW-1:0] get_out(int k);
        return (k == 0) ? out1 : (k == 1) ? out2 : out8;
    endfunction
    function automatic logic get_ack(int k);
        return (k == 0) ? ack1 : (k == 1) ? ack2 : ack8;
    endfunction
    function automatic logic get_busy(int k);
        return (k == 0) ? busy1 : (k == 1) ? busy2 : busy8;
    endfunction
    function automatic logic get_rdy(int k);
        return (k == 0) ? rdy1 : (k == 1) ? rdy2 : rdy8;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s lat%0d t=%0t: got %0h expected %0h", name, lat(k), $time, got, exp);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Transaction model: an access accepted at edge a completes at edge a+L and the
    // next accept is possible at edge a+L+2; nothing in between looks at the inputs.
    int            n_m      [3];
    bit            act_m    [3];
    int            acc_m    [3];
    bit            opw_m    [3];
    logic [AW-1:0] opa_m    [3];
    logic [DW-1:0] opd_m    [3];
    bit            rdy_m    [3];
    logic [DW-1:0] data_m   [3];
    bit            dknown_m [3];
    logic [DW-1:0] mem_m    [3][DEPTH];
    bit            mknown_m [3][DEPTH];

    initial begin
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < DEPTH; a++) begin
                mem_m[k][a]    = '0;
                mknown_m[k][a] = 1'b0;
            end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit rdy_old;
            rdy_old = rdy_m[k];
            if (!rst_n) begin
                n_m[k]      = 0;
                act_m[k]    = 1'b0;
                rdy_m[k]    = !CLR;
                data_m[k]   = '0;
                dknown_m[k] = 1'b1;
            end else begin
                n_m[k]++;
                if (act_m[k] && n_m[k] > acc_m[k] + lat(k) + 1) act_m[k] = 1'b0;
                if (!act_m[k] && rdy_old && cs && req) begin
                    act_m[k] = 1'b1;
                    acc_m[k] = n_m[k];
                    opw_m[k] = !we_n;
                    opa_m[k] = addr;
                    opd_m[k] = din;
                end
                if (act_m[k] && n_m[k] == acc_m[k] + lat(k)) begin
                    if (opw_m[k]) begin
                        mem_m[k][opa_m[k]]    = opd_m[k];
                        mknown_m[k][opa_m[k]] = 1'b1;
                    end else begin
                        data_m[k]   = mem_m[k][opa_m[k]];
                        dknown_m[k] = mknown_m[k][opa_m[k]];
                    end
                end
                if (CLR && !rdy_m[k] && n_m[k] >= DEPTH) begin
                    rdy_m[k] = 1'b1;
                    for (int a = 0; a < DEPTH; a++) begin
                        mem_m[k][a]    = CV;
                        mknown_m[k][a] = 1'b1;
                    end
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("ack",   k, 32'(get_ack(k)),  32'(act_m[k] && n_m[k] == acc_m[k] + lat(k)));
            chk("busy",  k, 32'(get_busy(k)), 32'(act_m[k] && n_m[k] <  acc_m[k] + lat(k)));
            chk("ready", k, 32'(get_rdy(k)),  32'(rdy_m[k]));
            if (!cs)               chk("out_z", k, 32'(get_out(k)), 32'(PULL));
            else if (dknown_m[k])  chk("out",   k, 32'(get_out(k)), 32'(data_m[k]));
        end
    end

    task automatic access(input bit w, input int a, input int d);
        @(negedge clk);
        cs = 1'b1; req = 1'b1; we_n = !w; addr = AW'(a); din = DW'(d);
        @(negedge clk);
        req = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int i;
        i = 0;
        while (!(rdy1 && rdy2 && rdy8) && i < 100) begin
            @(posedge clk); #2;
            i++;
        end
        lit(name, 32'(i), CLR ? 32'(DEPTH) : 32'd0);
    endtask

    initial begin
        int cnt [3];
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_ready("sweep_len");
        if (CLR) begin
            access(1'b0, 0, 0);
            lit("clear_rd0", 32'(out2), 32'(CV));
            access(1'b0, 15, 0);
            lit("clear_rd15", 32'(out8), 32'(CV));
        end
        for (int a = 0; a < DEPTH; a++) access(1'b1, a, a * 37 + 5);

        // Write 999 @5 with cycle-exact Ack/Busy checks
        @(negedge clk);
        cs = 1'b1; req = 1'b1; we_n = 1'b0; addr = 4'd5; din = 10'd999;
        @(posedge clk); #2;
        lit("wr_busy_accept", 32'(busy2), 32'd1);
        lit("wr_ack_accept",  32'(ack2),  32'd0);
        @(negedge clk) req = 1'b0;
        @(posedge clk); #2;
        lit("wr_l1_ack_e1", 32'(ack1),  32'd1);
        lit("wr_l2_ack_e1", 32'(ack2),  32'd0);
        lit("wr_l2_bsy_e1", 32'(busy2), 32'd1);
        @(posedge clk); #2;
        lit("wr_l2_ack_e2", 32'(ack2),  32'd1);
        lit("wr_l2_bsy_e2", 32'(busy2), 32'd0);
        repeat (10) @(negedge clk);

        // Read back @5
        @(negedge clk);
        req = 1'b1; we_n = 1'b1;
        @(posedge clk);
        @(negedge clk) req = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #2;
            if (e == 2) lit("rd_l2_out", 32'(out2), 32'd999);
            lit("rd_l8_ack", 32'(ack8), 32'(e == 8));
        end
        lit("rd_l8_out", 32'(out8), 32'd999);
        repeat (10) @(negedge clk);

        // Req held: one access per LATENCY+2 clocks
        @(negedge clk);
        req = 1'b1; we_n = 1'b1; addr = 4'd5;
        cnt = '{0, 0, 0};
        repeat (30) begin
            @(posedge clk); #2;
            cnt[0] += int'(ack1); cnt[1] += int'(ack2); cnt[2] += int'(ack8);
        end
        @(negedge clk) req = 1'b0;
        lit("held_acks_l1", 32'(cnt[0]), 32'd10);
        lit("held_acks_l2", 32'(cnt[1]), 32'd7);
        lit("held_acks_l8", 32'(cnt[2]), 32'd3);
        repeat (10) @(negedge clk);

        // Inputs changing while busy are ignored
        @(negedge clk);
        req = 1'b1; we_n = 1'b1; addr = 4'd3;
        @(negedge clk);
        req = 1'b0; we_n = 1'b0; addr = 4'd7; din = 10'h2AA;
        cnt[2] = 0;
        repeat (10) begin
            @(posedge clk); #2;
            cnt[2] += int'(ack8);
        end
        lit("busy_ign_acks", 32'(cnt[2]), 32'd1);
        lit("busy_ign_out",  32'(out8),   32'd116);
        access(1'b0, 7, 0);
        lit("busy_ign_m7",   32'(out2),   32'd264);

        // Reset aborts an accepted write
        @(negedge clk);
        req = 1'b1; we_n = 1'b0; addr = 4'd9; din = 10'd123;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; req = 1'b0;
        #1;
        lit("rst_out",  32'(out2), 32'd0);
        lit("rst_ack",  32'(ack1), 32'd0);
        lit("rst_busy", 32'(busy8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready("sweep_len_again");
        access(1'b0, 9, 0);
        lit("rst_m9", 32'(out2), CLR ? 32'(CV) : 32'd338);

        // CS low: bus released and Req ignored
        @(negedge clk);
        cs = 1'b0; req = 1'b1; we_n = 1'b0; addr = 4'd9; din = 10'd1;
        repeat (4) @(posedge clk);
        #2;
        lit("cs0_out_z", 32'(out2),  32'(PULL));
        lit("cs0_busy",  32'(busy2), 32'd0);
        @(negedge clk);
        cs = 1'b1; req = 1'b0;
        #1;
        lit("cs1_out", 32'(out2), CLR ? 32'(CV) : 32'd338);

        // Randomised traffic
        repeat (2000) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cs   = ($urandom_range(0, 4) != 0);
            req  = $urandom_range(0, 1) == 1;
            we_n = $urandom_range(0, 1) == 1;
            addr = AW'($urandom_range(0, DEPTH - 1));
            din  = DW'($urandom);
        end
        @(negedge clk);
        req = 1'b0; cs = 1'b1;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
